// File: rtl/console_pkg.sv
// Shared constants for the text console: screen geometry, control codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package console_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_CLR_ALL = 2'd0,
        ST_IDLE    = 2'd1,
        ST_CLR_ROW = 2'd2
    } state_t;

    // Printable ASCII range that gets stored in the character RAM
    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= 8'h20) && (ch <= 8'h7E);
    endfunction

endpackage

// File: rtl/char_ram.sv
// Character RAM: one write port, one synchronous read-first read port.
// Latency: write lands on the clock edge; read data valid 1 cycle after address.
// Backpressure: none; both ports accept every cycle.
module char_ram #(
    parameter int DEPTH  = 2400,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Array write; contents are deliberately left unreset, the console sweep initialises them
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; samples the array before a same-edge write, so it returns the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= 8'h00;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/char_console.sv
// Text console writer: interprets an ASCII stream, keeps cursor and character RAM.
// Latency: RAM write on the accepting edge; cursor_addr updates the following cycle.
// Backpressure: in_ready low during full-screen and row clear sweeps; sender holds its byte.
module char_console
    import console_pkg::*;
#(
    parameter int COLS   = console_pkg::COLS,
    parameter int ROWS   = console_pkg::ROWS,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ADDR_W-1:0] A_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_COLS     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_ONE    = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [COL_W-1:0]  COL_MAX    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE    = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0]  ROW_MAX    = ROW_W'(ROWS - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_sweep;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [ADDR_W-1:0]   r_cursor;

    logic                w_accept;
    logic                w_sweeping;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [7:0]          w_wdata;
    logic [ADDR_W-1:0]   w_col_ext;

    state_t              w_state_nxt;
    logic [ROW_W-1:0]    w_row_nxt;
    logic [COL_W-1:0]    w_col_nxt;
    logic [ADDR_W-1:0]   w_cursor_nxt;

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign cursor_addr = r_cursor;
    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_sweeping  = (r_state == ST_CLR_ALL) || (r_state == ST_CLR_ROW);
    assign w_col_ext   = {{(ADDR_W-COL_W){1'b0}}, r_col};

    // Write port: sweeps blank the cell under the counter, otherwise printable bytes go at the cursor
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cursor;
        w_wdata = in_data;
        if (w_sweeping) begin
            w_we    = 1'b1;
            w_waddr = r_sweep;
            w_wdata = CH_SPACE;
        end else begin
            w_we    = w_accept && is_printable(in_data);
        end
    end

    // Cursor and state update for an accepted byte in IDLE; address tracked by add/subtract only
    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_cursor_nxt = r_cursor;
        if (w_accept) begin
            if (is_printable(in_data)) begin
                if (r_col == COL_MAX) begin
                    w_col_nxt = '0;
                    if (r_row == ROW_MAX) begin
                        // No scrolling: wrap to the top and blank the row we land on
                        w_row_nxt    = '0;
                        w_cursor_nxt = '0;
                        w_state_nxt  = ST_CLR_ROW;
                    end else begin
                        w_row_nxt    = r_row + ROW_ONE;
                        w_cursor_nxt = r_cursor + A_ONE;
                    end
                end else begin
                    w_col_nxt    = r_col + COL_ONE;
                    w_cursor_nxt = r_cursor + A_ONE;
                end
            end else begin
                case (in_data)
                    CH_CR: begin
                        w_col_nxt    = '0;
                        w_cursor_nxt = r_cursor - w_col_ext;
                    end
                    CH_LF: begin
                        if (r_row == ROW_MAX) begin
                            w_row_nxt    = '0;
                            w_cursor_nxt = w_col_ext;
                            w_state_nxt  = ST_CLR_ROW;
                        end else begin
                            w_row_nxt    = r_row + ROW_ONE;
                            w_cursor_nxt = r_cursor + A_COLS;
                        end
                    end
                    CH_BS: begin
                        if (r_col != '0) begin
                            w_col_nxt    = r_col - COL_ONE;
                            w_cursor_nxt = r_cursor - A_ONE;
                        end
                    end
                    CH_FF: begin
                        w_state_nxt = ST_CLR_ALL;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // FSM, sweep counter and cursor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_CLR_ALL;
            r_sweep  <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_cursor <= '0;
        end else begin
            case (r_state)
                ST_CLR_ALL: begin
                    if (r_sweep == LAST_CELL) begin
                        r_state  <= ST_IDLE;
                        r_sweep  <= '0;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_cursor <= '0;
                    end else begin
                        r_sweep <= r_sweep + A_ONE;
                    end
                end
                ST_CLR_ROW: begin
                    // Wrap always lands on row 0, so the counter is the cell address directly
                    if (r_sweep == LAST_COL_A) begin
                        r_state <= ST_IDLE;
                        r_sweep <= '0;
                    end else begin
                        r_sweep <= r_sweep + A_ONE;
                    end
                end
                default: begin
                    r_state  <= w_state_nxt;
                    r_sweep  <= '0;
                    r_row    <= w_row_nxt;
                    r_col    <= w_col_nxt;
                    r_cursor <= w_cursor_nxt;
                end
            endcase
        end
    end

    char_ram #(
        .DEPTH  (CELLS),
        .ADDR_W (ADDR_W)
    ) u_char_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

endmodule

// File: tb/tb_char_console.sv
// Directed bench for char_console: reset sweep, text entry, wraps, FF under backpressure, mid-sweep reset.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: sender holds in_valid/in_data until in_ready is seen high.
module tb_char_console;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic [11:0] cursor_addr;
    logic        busy;

    int n_vec;
    int n_err;

    char_console #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one byte, waiting (bounded) for in_ready; returns cycles spent waiting
    task automatic send_byte(input logic [7:0] b, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 3000) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout byte=%02h in_ready stuck 0 after %0d cycles, required 1", b, waited);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [11:0] a, output logic [7:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    // Wait for in_ready, returning the number of cycles it stayed low
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] d;
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || cursor_addr !== 12'd0 || rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b busy=%b cur=%0d rd=%02h, required 0 1 0 00",
                     in_ready, busy, cursor_addr, rd_data);
        end
        rst_n = 1'b1;
        wait_ready(n);
        n_vec++;
        if (n !== 2400) begin
            n_err++;
            $display("FAIL init_clear_len got %0d cycles, required 2400", n);
        end
        read_cell(12'd0, d);
        n_vec++;
        if (d !== 8'h20) begin n_err++; $display("FAIL init_cell0 got %02h, required 20", d); end
        read_cell(12'd1234, d);
        n_vec++;
        if (d !== 8'h20) begin n_err++; $display("FAIL init_cell1234 got %02h, required 20", d); end
        read_cell(12'd2399, d);
        n_vec++;
        if (d !== 8'h20) begin n_err++; $display("FAIL init_cell2399 got %02h, required 20", d); end
    endtask

    task automatic test_text_cr();
        int w;
        logic [7:0] d;
        send_byte(8'h41, w);
        send_byte(8'h42, w);
        send_byte(8'h0D, w);
        send_byte(8'h43, w);
        n_vec++;
        if (cursor_addr !== 12'd1) begin
            n_err++;
            $display("FAIL cr_cursor got %0d, required 1", cursor_addr);
        end
        read_cell(12'd0, d);
        n_vec++;
        if (d !== 8'h43) begin n_err++; $display("FAIL cr_cell0 got %02h, required 43", d); end
        read_cell(12'd1, d);
        n_vec++;
        if (d !== 8'h42) begin n_err++; $display("FAIL cr_cell1 got %02h, required 42", d); end
    endtask

    task automatic test_line_wrap_bs();
        int w;
        logic [7:0] d;
        send_byte(8'h0C, w);
        for (int i = 0; i < 80; i++) send_byte(8'h78, w);
        send_byte(8'h79, w);
        n_vec++;
        if (cursor_addr !== 12'd81) begin
            n_err++;
            $display("FAIL wrap_cursor got %0d, required 81", cursor_addr);
        end
        for (int i = 0; i < 80; i++) begin
            read_cell(12'(i), d);
            n_vec++;
            if (d !== 8'h78) begin n_err++; $display("FAIL wrap_cell%0d got %02h, required 78", i, d); end
        end
        read_cell(12'd80, d);
        n_vec++;
        if (d !== 8'h79) begin n_err++; $display("FAIL wrap_cell80 got %02h, required 79", d); end
        send_byte(8'h08, w);
        n_vec++;
        if (cursor_addr !== 12'd80) begin
            n_err++;
            $display("FAIL bs_cursor got %0d, required 80", cursor_addr);
        end
        send_byte(8'h08, w);
        n_vec++;
        if (cursor_addr !== 12'd80) begin
            n_err++;
            $display("FAIL bs_col0_noop got %0d, required 80", cursor_addr);
        end
        read_cell(12'd80, d);
        n_vec++;
        if (d !== 8'h79) begin n_err++; $display("FAIL bs_no_erase got %02h, required 79", d); end
        send_byte(8'h01, w);
        send_byte(8'h7F, w);
        n_vec++;
        if (cursor_addr !== 12'd80) begin
            n_err++;
            $display("FAIL ignored_ctrl_cursor got %0d, required 80", cursor_addr);
        end
    endtask

    task automatic test_row_wrap();
        int w;
        int n;
        logic [7:0] d;
        send_byte(8'h0C, w);
        for (int i = 0; i < 80; i++) send_byte(8'h7A, w);
        for (int i = 0; i < 28; i++) send_byte(8'h0A, w);
        n_vec++;
        if (cursor_addr !== 12'd2320) begin
            n_err++;
            $display("FAIL lf_cursor_row29 got %0d, required 2320", cursor_addr);
        end
        for (int i = 0; i < 3; i++) send_byte(8'h71, w);
        send_byte(8'h0A, w);
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || cursor_addr !== 12'd3) begin
            n_err++;
            $display("FAIL clr_row_entry got rdy=%b busy=%b cur=%0d, required 0 1 3", in_ready, busy, cursor_addr);
        end
        wait_ready(n);
        n_vec++;
        if (n !== 80) begin n_err++; $display("FAIL clr_row_len got %0d cycles, required 80", n); end
        n_vec++;
        if (cursor_addr !== 12'd3) begin
            n_err++;
            $display("FAIL clr_row_cursor got %0d, required 3", cursor_addr);
        end
        for (int i = 0; i < 80; i++) begin
            read_cell(12'(i), d);
            n_vec++;
            if (d !== 8'h20) begin n_err++; $display("FAIL clr_row_cell%0d got %02h, required 20", i, d); end
        end
        read_cell(12'd2322, d);
        n_vec++;
        if (d !== 8'h71) begin n_err++; $display("FAIL row29_kept got %02h, required 71", d); end
    endtask

    task automatic test_ff_hold();
        int n;
        logic [7:0] d;
        in_valid = 1'b1;
        in_data  = 8'h0C;
        wait_ready(n);
        tick();
        in_data = 8'h50;
        wait_ready(n);
        n_vec++;
        if (n !== 2400) begin n_err++; $display("FAIL ff_sweep_len got %0d cycles, required 2400", n); end
        n_vec++;
        if (cursor_addr !== 12'd0) begin
            n_err++;
            $display("FAIL ff_cursor_home got %0d, required 0", cursor_addr);
        end
        tick();
        in_data = 8'h51;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (cursor_addr !== 12'd2) begin
            n_err++;
            $display("FAIL ff_hold_cursor got %0d, required 2", cursor_addr);
        end
        read_cell(12'd0, d);
        n_vec++;
        if (d !== 8'h50) begin n_err++; $display("FAIL ff_hold_cell0 got %02h, required 50", d); end
        read_cell(12'd1, d);
        n_vec++;
        if (d !== 8'h51) begin n_err++; $display("FAIL ff_hold_cell1 got %02h, required 51", d); end
        read_cell(12'd2, d);
        n_vec++;
        if (d !== 8'h20) begin n_err++; $display("FAIL ff_hold_cell2 got %02h, required 20", d); end
    endtask

    task automatic test_reset_mid_sweep();
        int w;
        int n;
        send_byte(8'h0C, w);
        rd_addr = 12'd2000;
        repeat (500) tick();
        n_vec++;
        if (rd_data !== 8'h20 || cursor_addr !== 12'd2) begin
            n_err++;
            $display("FAIL mid_sweep_pre got rd=%02h cur=%0d, required 20 2", rd_data, cursor_addr);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || cursor_addr !== 12'd0 || rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset_values got rdy=%b busy=%b cur=%0d rd=%02h, required 0 1 0 00",
                     in_ready, busy, cursor_addr, rd_data);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        wait_ready(n);
        n_vec++;
        if (n !== 2400) begin n_err++; $display("FAIL restart_clear_len got %0d cycles, required 2400", n); end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_addr  = 12'd0;
        repeat (3) tick();
        test_reset();
        test_text_cr();
        test_line_wrap_bs();
        test_row_wrap();
        test_ff_hold();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/char_console.md
# char_console

Text-mode character console that sits directly upstream of `vga_char`. It accepts an ASCII byte stream over a valid/ready handshake, interprets a small set of control codes, and maintains an 80x30 character RAM with a cursor. The renderer reads that RAM through a synchronous read port. It is the writer side of the text display; `vga_char` is the reader.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 30: rows per screen.
- `ADDR_W`, default 12: cell address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- `clk` input, 1 bit: system clock; single clock domain.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: the block accepts a byte this cycle.
- `in_data` input, 8 bits: ASCII byte.
- `rd_addr` input, ADDR_W bits: renderer cell address, `row*COLS+col`.
- `rd_data` output, 8 bits: character at `rd_addr`, registered.
- `cursor_addr` output, ADDR_W bits: current cursor cell address.
- `busy` output, 1 bit: a clear sweep is in progress.

## Operation
- States: CLR_ALL, IDLE, CLR_ROW.
- After reset, the state is CLR_ALL.
- CLR_ALL:
  - writes 0x20 to cells 0..COLS*ROWS-1, one per cycle;
  - at the end it homes the cursor to (0,0) and enters IDLE.
- IDLE:
  - `in_ready`=1; a byte is accepted when `in_valid & in_ready`.
- Printable bytes (0x20-0x7E):
  - the byte is written at the cursor;
  - col+1;
  - if col was COLS-1: col=0, row+1.
- 0x0D (CR): col=0.
- 0x0A (LF): row+1, col unchanged.
- 0x08 (BS): col-1; no-op at col 0; the cell is not erased.
- 0x0C (FF): enter CLR_ALL.
- All other bytes are accepted and ignored.
- Row advance from ROWS-1:
  - row wraps to 0 (no scrolling);
  - state becomes CLR_ROW for the new row.
- CLR_ROW:
  - writes 0x20 to the COLS cells of the cursor row, one per cycle;
  - then returns to IDLE;
  - the cursor holds its post-advance position.
- `in_ready`=0 and `busy`=1 in CLR_ALL and CLR_ROW.
- Cursor position: `cursor_addr = row*COLS + col`, maintained incrementally (no multiplier), registered.
- RAM contents are not reset by `rst_n`; only the sweep initialises them.

## Timing
- Reset values:
  - `in_ready`=0, `busy`=1, `cursor_addr`=0, `rd_data`=0x00;
  - state CLR_ALL, sweep counter 0.
- Write latency:
  - the RAM write happens on the accepting edge;
  - `cursor_addr` reflects the new position on the following cycle.
- Read port:
  - 1-cycle latency;
  - on a same-address write, `rd_data` shows the old value (read-first).
- Initial clear: the first cycle with `in_ready`=1 is exactly COLS*ROWS cycles (2400 at defaults) after `rst_n` deasserts.
- FF clear:
  - the accepting edge enters CLR_ALL;
  - the sweep is 2400 cycles;
  - the cursor is (0,0) when `in_ready` returns.
- CLR_ROW:
  - the row advance edge enters CLR_ROW;
  - COLS cycles later the state is IDLE and `in_ready`=1.
- `in_valid` while `in_ready`=0: the byte is not consumed; the sender holds it.
- `rst_n` asserted mid-sweep:
  - the sweep aborts immediately;
  - on release a full CLR_ALL restarts from cell 0.
- The read port stays live in every state, including reset release; `rd_data` may show partially cleared content.

## Structure
- Shared package `console_pkg`:
  - `COLS`, `ROWS`;
  - control code constants `CH_BS`, `CH_LF`, `CH_FF`, `CH_CR`, `CH_SPACE`;
  - state enum.
- Sub-module `char_ram`:
  - simple dual-port, one write port, one synchronous read-first read port;
  - depth COLS*ROWS, 8 bits wide;
  - no reset on the array; reset on the output register only.
- `char_console` holds the FSM, the cursor (row, col, addr) and the sweep counter.
- It is instantiated beside `vga_char`, with `rd_addr`/`rd_data` connected to it.

## Test plan
- Reset, then idle:
  - `in_ready` rises exactly 2400 cycles after `rst_n` release;
  - reads of cells 0, 1234 and 2399 return 0x20.
- Send "AB", CR, "C":
  - cell 0 = 0x43, cell 1 = 0x42;
  - `cursor_addr`=1.
- Send 80 × 'x', then 'y':
  - cells 0-79 = 0x78, cell 80 = 0x79;
  - `cursor_addr`=81.
- Place the cursor on row 29, fill row 0 with 'z', send LF:
  - `in_ready`=0 for 80 cycles;
  - row 0 reads all 0x20;
  - `cursor_addr` = col (row 0).
- Hold `in_valid`=1 with bytes during a FF sweep:
  - no byte is lost or duplicated;
  - the first byte after the sweep lands at cell 0.
- Assert `rst_n` 500 cycles into CLR_ALL:
  - outputs go to reset values;
  - after release `in_ready` stays 0 for a full 2400 cycles.
